// File: rtl/wb_trace_checker.sv
// Golden-trace checker for the CPU debug_wb_* commit port.
// Buffers expected commits in a FIFO and latches the first divergence.
module wb_trace_checker #(
  parameter int          DEPTH  = 16,
  parameter logic [31:0] END_PC = 32'h1c000100
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     gold_valid,
  output logic                     gold_ready,
  input  logic [31:0]              gold_pc,
  input  logic [4:0]               gold_wnum,
  input  logic [31:0]              gold_wdata,
  input  logic [31:0]              debug_wb_pc,
  input  logic [3:0]               debug_wb_rf_we,
  input  logic [4:0]               debug_wb_rf_wnum,
  input  logic [31:0]              debug_wb_rf_wdata,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [31:0]              err_pc,
  output logic [31:0]              err_exp_wdata,
  output logic [31:0]              err_got_wdata,
  output logic [31:0]              commit_cnt,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } gold_t;

  gold_t         mem [DEPTH];
  gold_t         head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic        push;
  logic        pop;
  logic        commit;
  logic        underflow;
  logic        mismatch;
  logic [31:0] mask;
  logic [1:0]  code_nx;
  logic [31:0] exp_nx;

  assign gold_ready = resetn && (count != FULL);
  assign fifo_count = count;
  assign head       = mem[rd_ptr];

  assign push      = gold_valid && gold_ready;
  assign commit    = (|debug_wb_rf_we) &&
                     (debug_wb_rf_wnum != 5'd0) && !done;
  assign pop       = commit && (count != '0);
  assign underflow = commit && (count == '0);

  assign mask = {{8{debug_wb_rf_we[3]}}, {8{debug_wb_rf_we[2]}},
                 {8{debug_wb_rf_we[1]}}, {8{debug_wb_rf_we[0]}}};

  assign mismatch = pop &&
    ((head.pc != debug_wb_pc) ||
     (head.wnum != debug_wb_rf_wnum) ||
     ((head.wdata & mask) != (debug_wb_rf_wdata & mask)));

  // underflow and mismatch are exclusive: a pop needs count != 0
  always_comb begin
    code_nx = 2'b00;
    exp_nx  = '0;
    unique case (1'b1)
      underflow: code_nx = 2'b10;
      mismatch: begin
        code_nx = 2'b01;
        exp_nx  = head.wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: gold_pc, wnum: gold_wnum, wdata: gold_wdata};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      commit_cnt    <= '0;
      err           <= 1'b0;
      err_code      <= 2'b00;
      err_pc        <= '0;
      err_exp_wdata <= '0;
      err_got_wdata <= '0;
      done          <= 1'b0;
    end else begin
      if (commit) commit_cnt <= commit_cnt + 32'd1;
      if (!err && (underflow || mismatch)) begin
        err           <= 1'b1;
        err_code      <= code_nx;
        err_pc        <= debug_wb_pc;
        err_exp_wdata <= exp_nx;
        err_got_wdata <= debug_wb_rf_wdata;
      end
      if (debug_wb_pc == END_PC) done <= 1'b1;
    end
  end

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Golden-trace checker for the CPU's trace debug interface, i.e. the receiving end of the debug_wb_* commit outputs. It buffers expected commits (pc, register number, write data) from a trace loader in a FIFO. It pops one entry per architectural register-file write and compares. It reports the first mismatch, counts checked commits and flags end of test. It sits in the SoC/testbench wrapper beside the CPU top and must be synthesizable for on-board self-check.

## Interface
Parameters:
- DEPTH, 16: golden FIFO entries; power of two, ≥ 2
- END_PC, 32'h1c000100: PC whose appearance on debug_wb_pc marks test completion

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- resetn  input  1  asynchronous, active-low reset
- gold_valid  input  1  golden entry offered
- gold_ready  output  1  FIFO accepts entry; = resetn && (count != DEPTH)
- gold_pc  input  32  expected commit PC
- gold_wnum  input  5  expected destination register
- gold_wdata  input  32  expected write data
- debug_wb_pc  input  32  CPU commit PC
- debug_wb_rf_we  input  4  CPU byte write enables
- debug_wb_rf_wnum  input  5  CPU destination register
- debug_wb_rf_wdata  input  32  CPU write data
- err  output  1  sticky error flag
- err_code  output  2  first error cause: 00 none, 01 mismatch, 10 underflow
- err_pc  output  32  debug_wb_pc of the first failing commit
- err_exp_wdata  output  32  golden wdata of the first failing commit (0 on underflow)
- err_got_wdata  output  32  CPU wdata of the first failing commit
- commit_cnt  output  32  number of commits checked
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy
- done  output  1  sticky; END_PC observed

## Operation
- FIFO: circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits, wrapping naturally, plus count.
  - Push when gold_valid && gold_ready.
  - Push and pop in the same cycle leave count unchanged.
- Commit: a cycle where |debug_wb_rf_we && debug_wb_rf_wnum != 0 && !done. Commits to r0 and commits after done are ignored: no pop, no count.
- On a commit with count != 0:
  - Pop the FIFO and increment commit_cnt (32-bit, wraps).
  - Build a 32-bit mask from we, each bit covering one byte.
  - Mismatch if pc differs, or wnum differs, or (gold_wdata & mask) != (debug_wb_rf_wdata & mask).
- On a commit with count == 0: underflow.
  - No pop, and no bypass of a same-cycle push.
  - commit_cnt still increments.
- Error capture:
  - On the first mismatch or underflow, set err=1, load err_code, err_pc, err_exp_wdata and err_got_wdata.
  - These hold until reset. Later errors do not overwrite them.
  - Checking and popping continue after an error.
- done: set when debug_wb_pc == END_PC in any cycle, independent of we. It is sticky.

## Timing
- Reset (resetn low, asynchronous): pointers, count, commit_cnt, err, err_code, err_pc, err_exp_wdata, err_got_wdata and done are all 0. gold_ready=0 while resetn is low and 1 on the first cycle after release.
- Inputs are sampled at the rising edge. err, err_* and commit_cnt reflect a commit one cycle later; no combinational path from debug_wb_* to outputs.
- An entry pushed at edge N can be popped by a commit sampled at edge N+1 or later.
- Full: gold_ready=0 when count==DEPTH. A same-cycle pop makes ready rise only on the next cycle.
- Back-to-back commits on consecutive cycles pop consecutive entries; sustained 1 commit/cycle is required.
- Reset asserted mid-test discards all FIFO contents and status immediately.

## Test plan
- Preload 3 entries (pc 1c000000/04/08, r1/r2/r3, data 1/2/3); CPU drives matching commits on 3 consecutive cycles -> commit_cnt=3, err=0, fifo_count=0.
- Entry {1c000010, r4, 0000_00AA}; commit we=0001, wdata FFFF_FFAA -> match. Same commit with we=1111 -> err=1, err_code=01, err_pc=1c000010, err_exp=000000AA, err_got=FFFFFFAA.
- Commit with FIFO empty, with a push in the same cycle -> err_code=10, err_exp=0, commit_cnt=1. A following matching commit pops the pushed entry and keeps err_code=10.
- Push DEPTH entries with gold_valid held high -> gold_ready low after DEPTH. Pop once -> ready high the next cycle. 2*DEPTH total pushes/pops verify pointer wrap order.
- Commits to r0 and commits with we=0 -> no pop, commit_cnt unchanged. debug_wb_pc=END_PC -> done=1 next cycle; later commits are ignored.
- Assert resetn low mid-stream with err=1 and fifo_count=5 -> all outputs 0 asynchronously. After release, gold_ready=1.
